// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and serialises it as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  tx_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [BAUD_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  stop_cnt_reg, stop_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  parity_reg, parity_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic                  ready_reg, ready_next;
    logic                  done_reg, done_next;
    logic                  bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    // tx_next is the value the line takes from the coming edge, so every
    // transition also decides the first bit of the state being entered.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        tx_next       = tx_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                if (tx_valid && ready_reg) begin
                    state_next  = START;
                    shift_next  = tx_data;
                    parity_next = (^tx_data) ^ (PARITY_ODD != 0);
                    tx_next     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next    = STOP;
                            stop_cnt_next = 1'b0;
                            tx_next       = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if ((STOP_BITS == 2) && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        busy_next  = (state_next != IDLE);
        ready_next = (state_next == IDLE);
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            ready_reg    <= ready_next;
            done_reg     <= done_next;
        end
    end

    assign tx       = tx_reg;
    assign tx_busy  = busy_reg;
    assign tx_ready = ready_reg;
    assign tx_done  = done_reg;

endmodule
